// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl
// Execute-stage issue controller for the multi-cycle multiply/divide unit.
// It latches one mult/div instruction, fires a single start pulse, and holds
// the pipeline stalled until the unit reports a result. The result (or a
// $rstatus exception code) then goes back as a one-cycle register write.
// A watchdog bounds the wait so that a lost ready strobe cannot hang the core.

module multdiv_issue_ctrl #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int TIMEOUT     = 40,
    parameter int RSTATUS_REG = 30,
    parameter int MUL_EXC     = 4,
    parameter int DIV_EXC     = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_is_div,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    output logic              stall,
    output logic              busy,
    output logic              ctrl_MULT,
    output logic              ctrl_DIV,
    output logic [DATA_W-1:0] op_A,
    output logic [DATA_W-1:0] op_B,
    input  logic [DATA_W-1:0] data_result,
    input  logic              data_exception,
    input  logic              data_resultRDY,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    // One spare count so the counter never has to wrap before the abort fires.
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state;
    logic              is_div_q;
    logic [REG_W-1:0]  rd_q;
    logic [WD_W-1:0]   wdog;

    // Stall is combinational so the issuing cycle itself already freezes the pipe.
    assign stall = ((state == IDLE) && issue_valid) || (state == START) || (state == WAIT);
    assign busy  = (state != IDLE);

    // Main controller: state, latched instruction, start pulses, watchdog and writeback registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            is_div_q    <= 1'b0;
            rd_q        <= '0;
            wdog        <= '0;
            op_A        <= '0;
            op_B        <= '0;
            ctrl_MULT   <= 1'b0;
            ctrl_DIV    <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            wb_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_valid) begin
                        is_div_q  <= issue_is_div;
                        rd_q      <= issue_rd;
                        op_A      <= issue_a;
                        op_B      <= issue_b;
                        ctrl_DIV  <= issue_is_div;
                        ctrl_MULT <= ~issue_is_div;
                        state     <= START;
                    end
                end
                START: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (data_resultRDY) begin
                        state    <= WB;
                        wb_valid <= 1'b1;
                        if (data_exception) begin
                            wb_rd   <= REG_W'(RSTATUS_REG);
                            wb_data <= is_div_q ? DATA_W'(DIV_EXC) : DATA_W'(MUL_EXC);
                        end else begin
                            wb_rd   <= rd_q;
                            wb_data <= data_result;
                        end
                    end else if (wdog == WD_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= WB;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb_multdiv_issue_ctrl
// Directed bench for the mult/div issue controller: a table of single
// transactions followed by hand-written multi-cycle sequences (spurious
// ready, back-to-back issue, watchdog abort, reset in the middle of a wait).

module tb_multdiv_issue_ctrl;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic        issue_is_div;
    logic [4:0]  issue_rd;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic        stall;
    logic        busy;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] op_A;
    logic [31:0] op_B;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_err;

    int vectors;
    int miscompares;

    typedef struct {
        logic        is_div;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        int          delay;
        logic        exc;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    multdiv_issue_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_is_div   (issue_is_div),
        .issue_rd       (issue_rd),
        .issue_a        (issue_a),
        .issue_b        (issue_b),
        .stall          (stall),
        .busy           (busy),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .op_A           (op_A),
        .op_B           (op_B),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .timeout_err    (timeout_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL sim_time_limit: got timeout, expected $finish before limit");
        $fatal(1, "[TB] time limit");
    end

    // What the multiply/divide unit would return for an operand pair.
    function automatic logic [31:0] unit_result(input logic is_div, input logic [31:0] a,
                                                input logic [31:0] b);
        if (is_div) return (b == 32'd0) ? 32'd0 : a / b;
        return a * b;
    endfunction

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive every controller input for the current cycle; result data is junk unless ready.
    task automatic applyStimulus(input logic valid, input logic is_div, input logic [4:0] rd,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic rdy, input logic [31:0] res, input logic exc);
        issue_valid    = valid;
        issue_is_div   = is_div;
        issue_rd       = rd;
        issue_a        = a;
        issue_b        = b;
        data_resultRDY = rdy;
        data_result    = rdy ? res : 32'hDEADBEEF;
        data_exception = rdy ? exc : 1'b0;
    endtask

    // One complete transaction from the table; cycle 0 is the issuing IDLE cycle.
    task automatic runVector(input int idx, input vec_t v);
        logic [31:0] res;
        int          k;
        int          bad;
        res = unit_result(v.is_div, v.a, v.b);
        k   = 1 + v.delay;
        @(negedge clock);
        applyStimulus(1'b1, v.is_div, v.rd, v.a, v.b, 1'b0, 32'd0, 1'b0);
        #1;
        checkOutput($sformatf("v%0d_issue_stall", idx), {31'd0, stall}, 32'd1);
        @(negedge clock);
        applyStimulus(1'b0, v.is_div, v.rd, v.a, v.b, 1'b0, 32'd0, 1'b0);
        #1;
        checkOutput($sformatf("v%0d_start_pulse", idx), {30'd0, ctrl_DIV, ctrl_MULT},
                    v.is_div ? 32'd2 : 32'd1);
        checkOutput($sformatf("v%0d_op_A", idx), op_A, v.a);
        checkOutput($sformatf("v%0d_op_B", idx), op_B, v.b);
        bad = 0;
        for (int c = 2; c <= k; c++) begin
            @(negedge clock);
            applyStimulus(1'b0, v.is_div, v.rd, v.a, v.b, (c == k), res, v.exc);
            #1;
            if (!stall || ctrl_MULT || ctrl_DIV || wb_valid || !busy) bad++;
        end
        checkOutput($sformatf("v%0d_wait_bad_cycles", idx), bad, 32'd0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        #1;
        checkOutput($sformatf("v%0d_wb_valid", idx), {31'd0, wb_valid}, 32'd1);
        checkOutput($sformatf("v%0d_wb_rd", idx), {27'd0, wb_rd}, {27'd0, v.exp_rd});
        checkOutput($sformatf("v%0d_wb_data", idx), wb_data, v.exp_data);
        checkOutput($sformatf("v%0d_wb_stall", idx), {31'd0, stall}, 32'd0);
        checkOutput($sformatf("v%0d_timeout_err", idx), {31'd0, timeout_err}, 32'd0);
        @(negedge clock);
        #1;
        checkOutput($sformatf("v%0d_back_idle", idx), {30'd0, busy, wb_valid}, 32'd0);
    endtask

    // Test sequence: reset, table, then the multi-cycle corner cases.
    initial begin
        int n_mult;
        int n_div;
        int n_wb;
        int n_busy;

        vectors     = 0;
        miscompares = 0;

        vecs[0] = '{1'b0, 5'd5,  32'd6,        32'd7,        33, 1'b0, 5'd5,  32'd42};
        vecs[1] = '{1'b1, 5'd9,  32'd100,      32'd0,        33, 1'b1, 5'd30, 32'd5};
        vecs[2] = '{1'b0, 5'd3,  32'h0001_0000, 32'h0001_0000, 10, 1'b1, 5'd30, 32'd4};
        vecs[3] = '{1'b1, 5'd12, 32'd100,      32'd7,        5,  1'b0, 5'd12, 32'd14};
        vecs[4] = '{1'b0, 5'd1,  32'd3,        32'd5,        1,  1'b0, 5'd1,  32'd15};
        vecs[5] = '{1'b1, 5'd31, 32'd1000,     32'd10,       40, 1'b0, 5'd31, 32'd100};
        vecs[6] = '{1'b0, 5'd0,  32'hFFFF_FFFF, 32'd2,       39, 1'b0, 5'd0,  32'hFFFF_FFFE};

        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset_flags", {26'd0, stall, busy, ctrl_MULT, ctrl_DIV, wb_valid, timeout_err},
                    32'd0);
        checkOutput("reset_op_A", op_A, 32'd0);
        checkOutput("reset_wb_data", wb_data, 32'd0);
        checkOutput("reset_wb_rd", {27'd0, wb_rd}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) runVector(i, vecs[i]);

        // Spurious ready in plain IDLE, in the issuing cycle and in START; real ready at cycle 6.
        n_wb = 0;
        for (int c = -1; c <= 10; c++) begin
            @(negedge clock);
            applyStimulus((c == 0), 1'b0, 5'd6, 32'd6, 32'd7, (c <= 1) || (c == 6),
                          (c == 6) ? 32'd42 : 32'h333, (c != 6));
            #1;
            if (wb_valid) n_wb++;
            if (c == 0) checkOutput("spur_idle_busy", {31'd0, busy}, 32'd0);
            if (c == 1) checkOutput("spur_start_pulse", {30'd0, ctrl_DIV, ctrl_MULT}, 32'd1);
            if (c == 7) begin
                checkOutput("spur_wb_rd", {27'd0, wb_rd}, 32'd6);
                checkOutput("spur_wb_data", wb_data, 32'd42);
            end
        end
        checkOutput("spur_wb_count", n_wb, 32'd1);

        // Back-to-back: mult 3*4 -> r2, then div 20/5 -> r3 with issue_valid held throughout.
        n_mult = 0;
        n_div  = 0;
        n_wb   = 0;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clock);
            applyStimulus((c <= 10), (c >= 6), (c >= 6) ? 5'd3 : 5'd2,
                          (c >= 6) ? 32'd20 : 32'd3, (c >= 6) ? 32'd5 : 32'd4,
                          (c == 4) || (c == 9), (c == 4) ? 32'd12 : 32'd4, 1'b0);
            #1;
            if (ctrl_MULT) n_mult++;
            if (ctrl_DIV) n_div++;
            if (wb_valid) n_wb++;
            if (c == 5) begin
                checkOutput("b2b_wb1_data", wb_data, 32'd12);
                checkOutput("b2b_wb1_rd", {27'd0, wb_rd}, 32'd2);
                checkOutput("b2b_wb1_op_A", op_A, 32'd3);
            end
            if (c == 6) checkOutput("b2b_idle_op_A_held", op_A, 32'd3);
            if (c == 7) begin
                checkOutput("b2b_div_pulse", {31'd0, ctrl_DIV}, 32'd1);
                checkOutput("b2b_op_A_new", op_A, 32'd20);
                checkOutput("b2b_op_B_new", op_B, 32'd5);
            end
            if (c == 10) begin
                checkOutput("b2b_wb2_data", wb_data, 32'd4);
                checkOutput("b2b_wb2_rd", {27'd0, wb_rd}, 32'd3);
            end
        end
        checkOutput("b2b_mult_pulses", n_mult, 32'd1);
        checkOutput("b2b_div_pulses", n_div, 32'd1);
        checkOutput("b2b_wb_count", n_wb, 32'd2);

        // Ready never comes: 40 WAIT cycles (2..41), aborted WB at 42, IDLE at 43.
        n_wb = 0;
        for (int c = 0; c <= 45; c++) begin
            @(negedge clock);
            applyStimulus((c == 0), 1'b0, 5'd7, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0);
            #1;
            if (wb_valid) n_wb++;
            if (c == 41) checkOutput("to_last_wait", {30'd0, timeout_err, stall}, 32'd1);
            if (c == 42) checkOutput("to_wb_cycle", {28'd0, timeout_err, wb_valid, stall, busy},
                                     32'h9);
            if (c == 45) checkOutput("to_sticky_idle", {30'd0, timeout_err, busy}, 32'd2);
        end
        checkOutput("to_wb_count", n_wb, 32'd0);

        // Reset pulled low in cycle 15 of a wait; the late ready at cycle 34 must be ignored.
        n_wb   = 0;
        n_busy = 0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clock);
            reset = (c == 15) ? 1'b0 : 1'b1;
            applyStimulus((c == 0), 1'b1, 5'd9, 32'd100, 32'd4, (c == 34), 32'd25, 1'b0);
            #1;
            if (c == 14) checkOutput("rst_pre_busy", {31'd0, busy}, 32'd1);
            if (c == 16) begin
                checkOutput("rst_flags", {26'd0, stall, busy, ctrl_MULT, ctrl_DIV, wb_valid,
                                          timeout_err}, 32'd0);
                checkOutput("rst_op_A", op_A, 32'd0);
                checkOutput("rst_op_B", op_B, 32'd0);
                checkOutput("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
                checkOutput("rst_wb_data", wb_data, 32'd0);
            end
            if (c >= 16) begin
                if (wb_valid) n_wb++;
                if (busy || ctrl_MULT || ctrl_DIV) n_busy++;
            end
        end
        checkOutput("rst_wb_count", n_wb, 32'd0);
        checkOutput("rst_busy_count", n_busy, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multdiv_issue_ctrl.md
# multdiv_issue_ctrl

Issue-side controller for the multi-cycle multiply/divide unit. It sits in the execute stage. It accepts a decoded mult/div instruction, latches the operands, emits a one-cycle `ctrl_MULT`/`ctrl_DIV` start pulse and stalls the pipeline until the unit's ready strobe. It then returns a single-cycle register-file write, or a `$rstatus` exception write, and releases the stall. A watchdog bounds the wait so a lost ready strobe cannot hang the core.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_W, 5, register index width
- TIMEOUT, 40, max WAIT cycles before abort (must exceed the unit's 34-cycle worst case)
- RSTATUS_REG, 30, exception destination register
- MUL_EXC, 4, value written to RSTATUS_REG on mult exception
- DIV_EXC, 5, value written to RSTATUS_REG on div exception

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- issue_valid  in  1  execute stage holds a mult/div instruction
- issue_is_div  in  1  1 = div, 0 = mult
- issue_rd  in  REG_W  destination register
- issue_a, issue_b  in  DATA_W  operands
- stall  out  1  freeze fetch/decode/execute
- busy  out  1  controller not in IDLE
- ctrl_MULT, ctrl_DIV  out  1  one-cycle start pulses to the unit
- op_A, op_B  out  DATA_W  latched operands, held stable from START through WB
- data_result  in  DATA_W  unit result
- data_exception  in  1  unit exception (overflow / divide by zero)
- data_resultRDY  in  1  unit result-valid strobe
- wb_valid  out  1  one-cycle register write request
- wb_rd  out  REG_W  write destination
- wb_data  out  DATA_W  write data
- timeout_err  out  1  sticky watchdog flag

## Operation
State machine: IDLE, START, WAIT, WB.

IDLE
- On `issue_valid`, latch issue_is_div, issue_rd, issue_a and issue_b, then go to START.
- Otherwise hold.

START
- Assert `ctrl_DIV` if div, else `ctrl_MULT`; exactly one of them, for exactly one cycle.
- Clear the watchdog and go to WAIT.

WAIT
- The watchdog increments every cycle.
- On `data_resultRDY`, capture data_result and data_exception, then go to WB.
- If the watchdog reaches TIMEOUT-1 without ready, set `timeout_err` and go to WB with the write suppressed.
- If ready and timeout occur in the same cycle, ready wins and `timeout_err` is not set.

WB
- `wb_valid` = 1, unless this WB followed a timeout.
- Without exception: wb_rd = latched rd, wb_data = captured result.
- With exception: wb_rd = RSTATUS_REG, wb_data = MUL_EXC or DIV_EXC, zero-extended.
- Unconditionally go to IDLE.

Other rules:
- `stall` = (IDLE && issue_valid) || START || WAIT. `stall` is low in WB, so the pipeline advances past the instruction in that cycle, and the next IDLE sees a fresh instruction.
- `busy` = state != IDLE.
- `data_resultRDY` is ignored in IDLE, START and WB.
- `timeout_err` clears only on reset.
- Latched operands and the destination do not change while `busy`.

## Timing
- Cycle 0: IDLE samples `issue_valid`=1; `stall`=1 combinationally.
- Cycle 1: START; ctrl pulse high, `stall`=1.
- Cycle 2 onward: WAIT.
- If ready is sampled in cycle k, WB occurs in cycle k+1 with `wb_valid` high and `stall` low.
- Minimum issue-to-writeback is 3 cycles. For the unit's ready at pulse+33, writeback lands at cycle 35.
- Back-to-back: the earliest START for a second instruction is the WB cycle + 2.

Reset values (reset low at a rising edge), effective the next cycle:
- State is IDLE.
- `stall`, `busy`, `ctrl_MULT`, `ctrl_DIV`, `wb_valid` and `timeout_err` are 0.
- `op_A`, `op_B`, `wb_rd` and `wb_data` are 0.
- Reset mid-WAIT aborts silently: no writeback, no pulse. The unit's own reset must be tied to the same reset.

Output registration:
- `ctrl_MULT`, `ctrl_DIV`, `wb_*` and `timeout_err` are registered outputs.
- `stall` is combinational from state and `issue_valid`.

## Test plan
- mult 6×7, rd=5, ready at pulse+33 -> single `ctrl_MULT` pulse at cycle 1; `stall` high for cycles 0–34; cycle 35: `wb_valid`, wb_rd=5, wb_data=42, `stall`=0.
- div 100/0, exception, rd=9 -> single `ctrl_DIV` pulse; WB writes wb_rd=30, wb_data=5; reg 9 is not written.
- Back-to-back mult then div with `issue_valid` held -> exactly two pulses, two `wb_valid` cycles, and op_A/op_B switch only after the first WB.
- Ready never asserted -> after TIMEOUT WAIT cycles: `timeout_err`=1 (sticky), a WB cycle with `wb_valid`=0 and `stall`=0, then IDLE.
- Reset low mid-WAIT at cycle 15, then ready pulsed at cycle 34 -> all outputs 0 from cycle 16 and no `wb_valid`.
- Spurious ready in IDLE and in START, then the real ready later -> ignored until WAIT; exactly one writeback carrying the real result.
